ysyx_25060166_mc_ctrl: RTL

Multi-cycle execution sequencer for the ysyx_25060166 core. It replaces the single-cycle fetch/execute scheme with a state machine that talks to instruction and data memory over valid/ready request and response channels. It owns the PC and the instruction register, sequences the combinational IDU/ALU/register-file datapath, and gates register writeback to exactly one cycle per retired instruction. A per-access timeout turns a hung bus into a sticky fault.

---
 rtl/ysyx_25060166_mc_ctrl_pkg.sv | 28 ++
 rtl/ysyx_25060166_bus_timer.sv | 37 +++
 rtl/ysyx_25060166_mc_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060166_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, reset PC default,
// instruction width and small decode helpers.
package ysyx_25060166_mc_ctrl_pkg;

    localparam int unsigned INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IF_REQ   = 3'd0,
        ST_IF_WAIT  = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_WB       = 3'd5,
        ST_FAULT    = 3'd6
    } mc_state_e;

    // States during which a bus transfer is outstanding and the timer runs
    function automatic logic is_bus_state(input mc_state_e s);
        return (s == ST_IF_REQ) || (s == ST_IF_WAIT) ||
               (s == ST_MEM_REQ) || (s == ST_MEM_WAIT);
    endfunction

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25060166_bus_timer.sv
// Per-access timeout counter: cleared on entry to a request state, counts while a
// transfer is outstanding, flags expiry on the TIMEOUT_CYC-th cycle.
module ysyx_25060166_bus_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter value equals cycles already spent, so the last allowed cycle is TIMEOUT_CYC-1
    assign expired_c_o = en_i && (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ysyx_25060166_mc_ctrl.sv
// Multi-cycle fetch/execute sequencer with valid/ready IMEM/DMEM channels and bus timeout.
// Optional performance counters are enabled with YSYX_25060166_PERF_CNT_EN.
module ysyx_25060166_mc_ctrl
    import ysyx_25060166_mc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    input  logic              dec_mem_ren,
    input  logic              dec_mem_wen,
    input  logic              dec_reg_wen,
    input  logic              alu_jump,
    input  logic [XLEN-1:0]   alu_addr,
    input  logic [XLEN-1:0]   alu_wdata,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_rdata,
    input  logic              dmem_rsp_err,
    output logic [XLEN-1:0]   load_data,
    output logic              reg_wen,
    output logic              retire,
    output logic              fault
`ifdef YSYX_25060166_PERF_CNT_EN
    ,
    output logic [63:0]       perf_cycle,
    output logic [63:0]       perf_instret
`endif
);

    mc_state_e         state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              jump_q, jump_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              bad_jump_q, bad_jump_d;
    logic              rwen_q, rwen_d;
    logic              dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              imem_req_valid_q, imem_req_valid_d;
    logic              dmem_req_valid_q, dmem_req_valid_d;
    logic              reg_wen_q, reg_wen_d;
    logic              retire_q, retire_d;
    logic              fault_q, fault_d;

    logic              bad_now;
    logic              rwen_now;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;

    ysyx_25060166_bus_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_bus_timer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (tmr_clr),
        .en_i        (tmr_en),
        .expired_c_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        jump_d       = jump_q;
        target_d     = target_q;
        bad_jump_d   = bad_jump_q;
        rwen_d       = rwen_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        load_data_d  = load_data_q;

        // WB strobes are registered, so resolve them on the edge that enters WB
        bad_now  = (state_q == ST_EXEC) ? (alu_jump && misaligned(alu_addr[1:0])) : bad_jump_q;
        rwen_now = (state_q == ST_EXEC) ? dec_reg_wen : rwen_q;

        case (state_q)
            ST_IF_REQ: begin
                if (tmr_expired) begin
                    state_d = ST_FAULT;
                end else if (imem_req_ready) begin
                    state_d = ST_IF_WAIT;
                end
            end
            ST_IF_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = ST_FAULT;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = ST_EXEC;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_EXEC: begin
                jump_d       = alu_jump;
                target_d     = alu_addr;
                bad_jump_d   = bad_now;
                rwen_d       = dec_reg_wen;
                dmem_addr_d  = alu_addr;
                dmem_wdata_d = alu_wdata;
                dmem_we_d    = dec_mem_wen;
                state_d      = (dec_mem_ren || dec_mem_wen) ? ST_MEM_REQ : ST_WB;
            end
            ST_MEM_REQ: begin
                if (tmr_expired) begin
                    state_d = ST_FAULT;
                end else if (dmem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_rsp_valid) begin
                    if (dmem_rsp_err) begin
                        state_d = ST_FAULT;
                    end else begin
                        if (!dmem_we_q) begin
                            load_data_d = dmem_rsp_rdata;
                        end
                        state_d = ST_WB;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                if (bad_jump_q) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d    = jump_q ? target_q : (pc_q + XLEN'(4));
                    state_d = ST_IF_REQ;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        imem_req_valid_d = (state_d == ST_IF_REQ);
        dmem_req_valid_d = (state_d == ST_MEM_REQ);
        retire_d         = (state_d == ST_WB) && !bad_now;
        reg_wen_d        = retire_d && rwen_now;
        fault_d          = (state_d == ST_FAULT);

        tmr_clr = ((state_d == ST_IF_REQ) || (state_d == ST_MEM_REQ)) && (state_d != state_q);
        tmr_en  = is_bus_state(state_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IF_REQ;
            pc_q             <= XLEN'(RESET_PC);
            inst_q           <= '0;
            jump_q           <= 1'b0;
            target_q         <= '0;
            bad_jump_q       <= 1'b0;
            rwen_q           <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
            load_data_q      <= '0;
            imem_req_valid_q <= 1'b1;
            dmem_req_valid_q <= 1'b0;
            reg_wen_q        <= 1'b0;
            retire_q         <= 1'b0;
            fault_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inst_q           <= inst_d;
            jump_q           <= jump_d;
            target_q         <= target_d;
            bad_jump_q       <= bad_jump_d;
            rwen_q           <= rwen_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            load_data_q      <= load_data_d;
            imem_req_valid_q <= imem_req_valid_d;
            dmem_req_valid_q <= dmem_req_valid_d;
            reg_wen_q        <= reg_wen_d;
            retire_q         <= retire_d;
            fault_q          <= fault_d;
        end
    end

    assign imem_req_valid = imem_req_valid_q;
    assign imem_addr      = pc_q;
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign dmem_req_valid = dmem_req_valid_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign load_data      = load_data_q;
    assign reg_wen        = reg_wen_q;
    assign retire         = retire_q;
    assign fault          = fault_q;

`ifdef YSYX_25060166_PERF_CNT_EN
    logic [63:0] perf_cycle_q;
    logic [63:0] perf_instret_q;

    // Free-running until the core faults; instret follows the registered retire pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle_q   <= '0;
            perf_instret_q <= '0;
        end else begin
            if (state_q != ST_FAULT) begin
                perf_cycle_q <= perf_cycle_q + 64'd1;
            end
            if (retire_q) begin
                perf_instret_q <= perf_instret_q + 64'd1;
            end
        end
    end

    assign perf_cycle   = perf_cycle_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule
